flappy_bird_pio_bank: RTL

FLAPPY_BIRD_PIO_BANK -- requirements
Module: flappy_bird_pio_bank

---
 rtl/flappy_bird_pio_bank.sv | 118 +++++++++++
 1 files changed

// File: rtl/flappy_bird_pio_bank.sv
// Double-buffered output register bank on an Avalon-MM slave. Software writes SHADOW
// registers, and all channels are copied to ACTIVE together on a frame edge or a CTRL commit.
module flappy_bird_pio_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int AW     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic                    frame_sync,
  output logic [NUM_CH*WIDTH-1:0] out_port,
  output logic                    commit_pulse
);
  localparam int TW = NUM_CH * WIDTH;

  logic [TW-1:0]     shadow_q, shadow_d;
  logic [TW-1:0]     active_q, active_d;
  logic              imm_q, imm_d;
  logic              pending_q, pending_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              frame_sync_q, frame_sync_d;
  logic              sync_mask_q, sync_mask_d;
  logic              commit_pulse_q, commit_pulse_d;
  logic [31:0]       addr_s;
  logic              wr_s;
  logic              ctrl_wr_s;
  logic              sync_edge_s;
  logic              commit_s;
  logic [NUM_CH-1:0] ch_wr_s;
  logic              unused_s;

  assign unused_s = ^writedata;

  // Decode bus writes, detect commit events and compute the next register state.
  always_comb begin
    addr_s    = 32'(address);
    wr_s      = chipselect & ~write_n;
    ctrl_wr_s = wr_s & (addr_s == 32'd0);
    ch_wr_s   = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wr_s[i] = wr_s & (addr_s == 32'(4 + 2 * i));
    end

    // sync_mask_q hides a frame_sync level that was already high while reset was held.
    sync_edge_s    = frame_sync & ~frame_sync_q & ~sync_mask_q;
    commit_s       = sync_edge_s | (ctrl_wr_s & writedata[1]);
    frame_sync_d   = frame_sync;
    sync_mask_d    = 1'b0;
    commit_pulse_d = commit_s;

    shadow_d = shadow_q;
    active_d = commit_s ? shadow_q : active_q;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i*WIDTH +: WIDTH] = ch_wr_s[i] ? writedata[WIDTH-1:0]
                                              : shadow_d[i*WIDTH +: WIDTH];
      active_d[i*WIDTH +: WIDTH] = (ch_wr_s[i] & imm_q) ? writedata[WIDTH-1:0]
                                                         : active_d[i*WIDTH +: WIDTH];
    end

    if ((|ch_wr_s) && !imm_q) begin
      pending_d = 1'b1;
    end else if (commit_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    frame_cnt_d = (commit_s & pending_q) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    imm_d       = ctrl_wr_s ? writedata[0] : imm_q;
  end

  // Zero-wait-state read mux; unmapped addresses fall through to zero.
  always_comb begin
    readdata = 32'd0;
    if (addr_s == 32'd0) begin
      readdata = {29'd0, pending_q, 1'b0, imm_q};
    end else if (addr_s == 32'd1) begin
      readdata = {16'd0, frame_cnt_q};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        readdata = (addr_s == 32'(4 + 2 * i)) ? 32'(shadow_q[i*WIDTH +: WIDTH]) : readdata;
        readdata = (addr_s == 32'(5 + 2 * i)) ? 32'(active_q[i*WIDTH +: WIDTH]) : readdata;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q       <= {TW{1'b0}};
      active_q       <= {TW{1'b0}};
      imm_q          <= 1'b0;
      pending_q      <= 1'b0;
      frame_cnt_q    <= 16'd0;
      frame_sync_q   <= 1'b0;
      sync_mask_q    <= frame_sync;
      commit_pulse_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      imm_q          <= imm_d;
      pending_q      <= pending_d;
      frame_cnt_q    <= frame_cnt_d;
      frame_sync_q   <= frame_sync_d;
      sync_mask_q    <= sync_mask_d;
      commit_pulse_q <= commit_pulse_d;
    end
  end

  assign out_port     = active_q;
  assign commit_pulse = commit_pulse_q;

endmodule
